// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: a Moore FSM that sequences fetch/decode/execute/memory/writeback.
// It adds a memory-ready handshake with a wait timeout, a sticky trap state and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int SUPPORT_BNE = 1,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       imm_src,
  output logic [2:0]       alu_control,
  output logic             trap,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam int                WAIT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WAIT_W-1:0]  r_wait;
  logic [CNT_W-1:0]   r_instret;

  logic               w_mem_req;
  logic               w_mem_write;
  logic               w_ir_write;
  logic               w_pc_write;
  logic               w_reg_write;
  logic               w_timeout;
  logic               w_waiting;
  logic               w_retire;
  logic               w_fn_ok;
  logic [2:0]         w_alu_fn;
  logic               w_br_ok;
  logic               w_br_take;

  // Funct decode shared by EXECR and EXECI; sub only exists for register-register ops.
  always_comb begin
    w_fn_ok  = 1'b1;
    w_alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  w_alu_fn = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  w_alu_fn = ALU_SLT;
      3'b100:  w_alu_fn = ALU_XOR;
      3'b110:  w_alu_fn = ALU_OR;
      3'b111:  w_alu_fn = ALU_AND;
      default: w_fn_ok  = 1'b0;
    endcase
  end

  assign w_br_ok   = (funct3 == 3'b000) || ((SUPPORT_BNE != 0) && (funct3 == 3'b001));
  assign w_br_take = (funct3 == 3'b000) ? zero : ~zero;

  // The timeout fires on the cycle that would be the TIMEOUT-th wait; a ready on that cycle still wins.
  assign w_timeout = (TIMEOUT > 0) && !mem_ready && (r_wait == TO_LAST);

  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    adr_src     = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    imm_src     = 2'b00;
    alu_control = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 2'b10;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = w_br_ok ? S_BRANCH : S_TRAP;
          OP_JAL:            w_next = S_JAL;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = op[5] ? 2'b01 : 2'b00;
        w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready)      w_next = S_MEMWB;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        adr_src     = 1'b1;
        w_mem_write = mem_ready;
        if (mem_ready)      w_next = S_FETCH;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = w_alu_fn;
        w_next      = w_fn_ok ? S_ALUWB : S_TRAP;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = w_alu_fn;
        w_next      = w_fn_ok ? S_ALUWB : S_TRAP;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        w_pc_write  = w_br_take;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        w_reg_write = 1'b1;
        w_pc_write  = 1'b1;
        w_next      = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  assign w_waiting = (r_state inside {S_FETCH, S_MEMREAD, S_MEMWRITE}) && !mem_ready &&
                     (w_next == r_state);
  assign w_retire  = (w_next == S_FETCH) &&
                     (r_state inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_JAL});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_waiting ? r_wait + 1'b1 : '0;
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

  // Strobes are held off for the whole reset, including the cycle reset is asserted mid-access.
  assign mem_req   = w_mem_req   & rst;
  assign mem_write = w_mem_write & rst;
  assign ir_write  = w_ir_write  & rst;
  assign pc_write  = w_pc_write  & rst;
  assign reg_write = w_reg_write & rst;

  assign trap    = (r_state == S_TRAP);
  assign instret = r_instret;
  assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: an instruction-level model queues the expected
// per-cycle outputs, and a monitor compares them against the DUT on every falling edge.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [3:0]  st;
    logic        req;
    logic        asrc;
    logic        mw;
    logic        irw;
    logic        pcw;
    logic        rw;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [1:0]  rs;
    logic [1:0]  imm;
    logic [2:0]  alu;
    logic        trap;
    logic [31:0] cnt;
  } rec_t;

  localparam logic [3:0] T_FETCH = 4'd0, T_DECODE = 4'd1, T_MEMADR = 4'd2, T_MEMREAD = 4'd3;
  localparam logic [3:0] T_MEMWB = 4'd4, T_MEMWRITE = 4'd5, T_EXECR = 4'd6, T_EXECI = 4'd7;
  localparam logic [3:0] T_ALUWB = 4'd8, T_BRANCH = 4'd9, T_JAL = 4'd10, T_TRAP = 4'd11;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic        req_a, adr_a, mw_a, irw_a, pcw_a, rw_a, trap_a;
  logic [1:0]  asa_a, asb_a, rs_a, imm_a;
  logic [2:0]  alu_a;
  logic [31:0] cnt_a;
  logic [3:0]  st_a;

  logic        req_b, adr_b, mw_b, irw_b, pcw_b, rw_b, trap_b;
  logic [1:0]  asa_b, asb_b, rs_b, imm_b;
  logic [2:0]  alu_b;
  logic [2:0]  cnt_b;
  logic [3:0]  st_b;

  multicycle_control_unit #(.SUPPORT_BNE(1), .TIMEOUT(4), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .mem_ready(mem_ready), .mem_req(req_a), .adr_src(adr_a), .mem_write(mw_a),
    .ir_write(irw_a), .pc_write(pcw_a), .reg_write(rw_a), .alu_src_a(asa_a),
    .alu_src_b(asb_a), .result_src(rs_a), .imm_src(imm_a), .alu_control(alu_a),
    .trap(trap_a), .instret(cnt_a), .state_o(st_a)
  );

  multicycle_control_unit #(.SUPPORT_BNE(0), .TIMEOUT(0), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .mem_ready(mem_ready), .mem_req(req_b), .adr_src(adr_b), .mem_write(mw_b),
    .ir_write(irw_b), .pc_write(pcw_b), .reg_write(rw_b), .alu_src_a(asa_b),
    .alu_src_b(asb_b), .result_src(rs_b), .imm_src(imm_b), .alu_control(alu_b),
    .trap(trap_b), .instret(cnt_b), .state_o(st_b)
  );

  rec_t act_a, act_b;
  assign act_a = {st_a, req_a, adr_a, mw_a, irw_a, pcw_a, rw_a, asa_a, asb_a, rs_a, imm_a,
                  alu_a, trap_a, cnt_a};
  assign act_b = {st_b, req_b, adr_b, mw_b, irw_b, pcw_b, rw_b, asa_b, asb_b, rs_b, imm_b,
                  alu_b, trap_b, {29'd0, cnt_b}};

  rec_t        exq[$];
  int          total = 0;
  int          bad = 0;
  bit          sel = 1'b0;
  bit          done = 1'b0;
  int          m_to = 4;
  bit          m_bne = 1'b1;
  logic [31:0] m_cnt = 32'd0;
  logic [31:0] m_mask = 32'hFFFF_FFFF;

  function automatic rec_t r(input logic [3:0] st, input logic req, input logic asrc,
                             input logic mw, input logic irw, input logic pcw, input logic rw,
                             input logic [1:0] a, input logic [1:0] b, input logic [1:0] rs,
                             input logic [1:0] imm, input logic [2:0] alu);
    rec_t e;
    e.st = st; e.req = req; e.asrc = asrc; e.mw = mw; e.irw = irw; e.pcw = pcw; e.rw = rw;
    e.a = a; e.b = b; e.rs = rs; e.imm = imm; e.alu = alu;
    e.trap = (st == T_TRAP);
    e.cnt = m_cnt & m_mask;
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock of stimulus: apply inputs, queue what the DUT must show, advance.
  task automatic cyc(input logic mr, input logic rv, input rec_t e);
    mem_ready = mr;
    rst = rv;
    exq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    m_cnt = 32'd0;
    for (int i = 0; i < n; i++)
      cyc(rb(), 1'b0, r(T_FETCH, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000));
  endtask

  task automatic trap_cycles(input int n);
    for (int i = 0; i < n; i++)
      cyc(rb(), 1'b1, r(T_TRAP, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
  endtask

  task automatic fetch(input int fw, output bit tr);
    tr = 1'b0;
    for (int i = 0; i < fw; i++) begin
      cyc(1'b0, 1'b1, r(T_FETCH, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000));
      if (m_to > 0 && i + 1 == m_to) begin tr = 1'b1; return; end
    end
    cyc(1'b1, 1'b1, r(T_FETCH, 1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000));
  endtask

  task automatic mem_access(input logic [3:0] st, input int w, output bit tr);
    tr = 1'b0;
    for (int i = 0; i < w; i++) begin
      cyc(1'b0, 1'b1, r(st, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
      if (m_to > 0 && i + 1 == m_to) begin tr = 1'b1; return; end
    end
    cyc(1'b1, 1'b1, r(st, 1, 1, st == T_MEMWRITE, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int fw, input int mw, output bit tr);
    bit         legal;
    logic [2:0] alu;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    fetch(fw, tr);
    if (tr) return;
    cyc(rb(), 1'b1, r(T_DECODE, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000));
    case (o)
      LOAD, STORE: begin
        cyc(rb(), 1'b1, r(T_MEMADR, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00,
                          (o == STORE) ? 2'b01 : 2'b00, 3'b000));
        mem_access((o == STORE) ? T_MEMWRITE : T_MEMREAD, mw, tr);
        if (tr) return;
        if (o == LOAD)
          cyc(rb(), 1'b1, r(T_MEMWB, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000));
        m_cnt++;
      end
      RT, IT: begin
        legal = 1'b1;
        alu = 3'b000;
        case (f3)
          3'b000:  alu = (o == RT && f7) ? 3'b001 : 3'b000;
          3'b010:  alu = 3'b101;
          3'b100:  alu = 3'b100;
          3'b110:  alu = 3'b011;
          3'b111:  alu = 3'b010;
          default: legal = 1'b0;
        endcase
        cyc(rb(), 1'b1, r((o == RT) ? T_EXECR : T_EXECI, 0, 0, 0, 0, 0, 0, 2'b10,
                          (o == RT) ? 2'b00 : 2'b01, 2'b00, 2'b00, alu));
        if (!legal) begin tr = 1'b1; return; end
        cyc(rb(), 1'b1, r(T_ALUWB, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        m_cnt++;
      end
      BR: begin
        if (!(f3 == 3'b000 || (f3 == 3'b001 && m_bne))) begin tr = 1'b1; return; end
        cyc(rb(), 1'b1, r(T_BRANCH, 0, 0, 0, 0, (f3 == 3'b000) ? z : !z, 0, 2'b10, 2'b00,
                          2'b00, 2'b00, 3'b001));
        m_cnt++;
      end
      JAL: begin
        cyc(rb(), 1'b1, r(T_JAL, 0, 0, 0, 0, 1, 1, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000));
        m_cnt++;
      end
      default: tr = 1'b1;
    endcase
  endtask

  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input int fw, input int mw, input int ntrap);
    bit tr;
    run_instr(o, f3, f7, z, fw, mw, tr);
    if (tr) begin
      trap_cycles(ntrap);
      do_reset(2);
    end
  endtask

  task automatic random_instrs(input int n, input int maxw);
    logic [6:0] ops [7];
    logic [6:0] o;
    int         fw, mw;
    ops = '{LOAD, STORE, RT, IT, BR, JAL, 7'd0};
    for (int i = 0; i < n; i++) begin
      o = ops[$urandom_range(0, 6)];
      if (o == 7'd0) o = 7'($urandom_range(0, 127));
      fw = ($urandom_range(0, 7) == 0) ? $urandom_range(3, maxw) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 7) == 0) ? $urandom_range(3, maxw) : $urandom_range(0, 2);
      instr(o, 3'($urandom_range(0, 7)), rb(), rb(), fw, mw, $urandom_range(1, 4));
    end
  endtask

  initial begin
    bit tr;
    @(posedge clk);
    #1;
    do_reset(2);
    instr(RT, 3'b000, 1'b0, 1'b0, 0, 0, 3);
    instr(RT, 3'b000, 1'b1, 1'b0, 0, 0, 3);
    instr(IT, 3'b000, 1'b1, 1'b0, 0, 0, 3);
    instr(IT, 3'b010, 1'b0, 1'b0, 1, 0, 3);
    instr(RT, 3'b100, 1'b0, 1'b0, 0, 0, 3);
    instr(RT, 3'b110, 1'b0, 1'b0, 0, 0, 3);
    instr(IT, 3'b111, 1'b0, 1'b0, 0, 0, 3);
    instr(LOAD, 3'b010, 1'b0, 1'b0, 0, 3, 3);
    instr(STORE, 3'b010, 1'b0, 1'b0, 1, 2, 3);
    instr(BR, 3'b000, 1'b0, 1'b1, 0, 0, 3);
    instr(BR, 3'b000, 1'b0, 1'b0, 0, 0, 3);
    instr(BR, 3'b001, 1'b0, 1'b1, 0, 0, 3);
    instr(BR, 3'b001, 1'b0, 1'b0, 0, 0, 3);
    instr(JAL, 3'b000, 1'b0, 1'b0, 0, 0, 3);
    instr(RT, 3'b001, 1'b0, 1'b0, 0, 0, 3);
    instr(BR, 3'b100, 1'b0, 1'b1, 0, 0, 3);
    instr(RT, 3'b000, 1'b0, 1'b0, 0, 0, 3);
    instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 10);
    instr(RT, 3'b000, 1'b0, 1'b0, 4, 0, 2);
    instr(RT, 3'b000, 1'b0, 1'b0, 3, 0, 2);
    instr(LOAD, 3'b010, 1'b0, 1'b0, 0, 4, 2);
    instr(LOAD, 3'b010, 1'b0, 1'b0, 0, 3, 2);
    instr(STORE, 3'b010, 1'b0, 1'b0, 0, 4, 2);
    instr(STORE, 3'b010, 1'b0, 1'b0, 2, 3, 2);
    // Reset arriving in the middle of a load that is still waiting on memory.
    op = LOAD; funct3 = 3'b010;
    fetch(0, tr);
    cyc(1'b0, 1'b1, r(T_DECODE, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000));
    cyc(1'b0, 1'b1, r(T_MEMADR, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000));
    cyc(1'b0, 1'b1, r(T_MEMREAD, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    cyc(1'b0, 1'b1, r(T_MEMREAD, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    do_reset(1);
    if (st_a !== T_FETCH || cnt_a !== 32'd0 || trap_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_access st=%0d cnt=%0d trap=%b", st_a, cnt_a, trap_a);
    end
    if (req_a !== 1'b0 || rw_a !== 1'b0 || pcw_a !== 1'b0 || irw_a !== 1'b0 || mw_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_strobes req=%b rw=%b pcw=%b irw=%b mw=%b",
               req_a, rw_a, pcw_a, irw_a, mw_a);
    end
    instr(JAL, 3'b000, 1'b0, 1'b0, 0, 0, 2);
    random_instrs(150, 6);

    sel = 1'b1; m_to = 0; m_bne = 1'b0; m_mask = 32'h7;
    do_reset(2);
    if (st_b !== T_FETCH || cnt_b !== 3'd0 || trap_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_b st=%0d cnt=%0d trap=%b", st_b, cnt_b, trap_b);
    end
    if (req_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_b_req req=%b", req_b);
    end
    instr(BR, 3'b001, 1'b0, 1'b1, 0, 0, 3);
    instr(BR, 3'b000, 1'b0, 1'b1, 0, 0, 3);
    instr(RT, 3'b000, 1'b0, 1'b0, 20, 0, 3);
    instr(LOAD, 3'b010, 1'b0, 1'b0, 0, 20, 3);
    instr(STORE, 3'b010, 1'b0, 1'b0, 0, 20, 3);
    for (int i = 0; i < 10; i++) instr(JAL, 3'b000, 1'b0, 1'b0, 0, 0, 3);
    random_instrs(40, 8);
    done = 1'b1;
  end

  always @(negedge clk) begin
    rec_t e, a;
    if (exq.size() > 0) begin
      e = exq.pop_front();
      a = sel ? act_b : act_a;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle_check n=%0d dut=%0d got st=%0d bits=%h want st=%0d bits=%h",
                 total, sel, a.st, a, e.st, e);
      end
    end else if (done) begin
      if (total < 100) begin
        bad++;
        $display("FAIL too_few_cycles total=%0d", total);
      end
      if (bad != 0) $display("FAIL summary bad=%0d", bad);
      else          $display("PASS all checks");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Next-generation RV32I control unit for the multicycle datapath. It replaces the single-cycle decoder pair with a Moore finite-state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It also adds a memory ready handshake with a timeout, an illegal-instruction trap, optional BNE support and a retired-instruction counter. It sits between the instruction register / ALU flags and the shared-memory multicycle datapath.

Parameters:
SUPPORT_BNE, 1, 1: decode funct3=001 branches as BNE; 0: treat them as illegal
TIMEOUT, 16, maximum cycles a memory state waits for mem_ready before trapping; 0 disables the timeout
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous active-low reset
op  in  7  instruction opcode from the IR
funct3  in  3  instruction funct3
funct7b5  in  1  instruction bit 30
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access requested
adr_src  out  1  0=PC, 1=ALUOut as memory address
mem_write  out  1  store strobe
ir_write  out  1  load IR
pc_write  out  1  update PC
reg_write  out  1  register file write
alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1
alu_src_b  out  2  00=rs2, 01=imm, 10=const 4
result_src  out  2  00=ALUOut, 01=Data, 10=ALU result
imm_src  out  2  00=I, 01=S, 10=B, 11=J
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
trap  out  1  illegal instruction or timeout; sticky
instret  out  CNT_W  retired-instruction count
state_o  out  4  current state, for debug

Behaviour:
- Reset
  - rst low asynchronously sets state to FETCH and clears trap, instret and the wait counter.
  - While rst is low, pc_write, ir_write, reg_write, mem_write and mem_req are forced to 0.
- Output style
  - Moore outputs decoded from the state; write strobes in memory states are additionally qualified by mem_ready.
  - Unlisted outputs are 0.
  - alu_control: add or sub per the state; funct-decoded in EXECR/EXECI.
- States and transitions
  - FETCH: mem_req=1, adr_src=0. On mem_ready: ir_write=1, pc_write=1, PC+4 computed (alu_src_a=00, alu_src_b=10, result_src=10), go to DECODE. Otherwise hold.
  - DECODE: computes the branch target (alu_src_a=01, alu_src_b=01, imm_src=10). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - anything else -> TRAP
  - MEMADR: rs1+imm; imm_src=00 for load, 01 for store. Next is MEMREAD for load, MEMWRITE for store.
  - MEMREAD: mem_req=1, adr_src=1. On mem_ready go to MEMWB.
  - MEMWB: result_src=01, reg_write=1, then FETCH.
  - MEMWRITE: mem_req=1, adr_src=1, mem_write=mem_ready. On mem_ready go to FETCH.
  - EXECR: alu_src_a=10, alu_src_b=00, then ALUWB.
  - EXECI: alu_src_a=10, alu_src_b=01, imm_src=00, then ALUWB.
  - ALUWB: result_src=00, reg_write=1, then FETCH.
  - BRANCH: sub of rs1 and rs2; result_src=00.
    - pc_write = zero for funct3=000 (BEQ).
    - pc_write = ~zero for funct3=001 when SUPPORT_BNE=1.
    - Then FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, result_src=00, reg_write=1, pc_write=1, then FETCH.
  - TRAP: terminal; all strobes 0. Exited only by reset.
- Funct decode (EXECR/EXECI)
  - funct3=000: sub only when op[5]=1 and funct7b5=1, else add.
  - funct3 010 -> slt, 100 -> xor, 110 -> or, 111 -> and.
  - Any other funct3 -> TRAP with no reg_write.
  - Illegal branch funct3 in DECODE -> TRAP.
- Timeout
  - The wait counter increments on each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0, and clears on leaving the state.
  - When TIMEOUT>0 and the counter reaches TIMEOUT, the next state is TRAP.
  - mem_ready arriving on that same cycle wins: the access completes normally.
- trap is 1 exactly while in TRAP.
- instret increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or JAL. It wraps modulo 2^CNT_W.
- Reset mid-access: the state returns to FETCH immediately; no strobe fires in the reset cycle.

Test Plan:
1. add x3,x1,x2 (op 0110011, f3 000, f7b5 0) with mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB, FETCH; alu_control=000; reg_write=1 in cycle 4; instret 0->1.
2. sub (f7b5=1) then addi with f7b5=1 (op 0010011) -> alu_control=001 for sub, 000 for addi.
3. lw with mem_ready held low 3 cycles in MEMREAD -> state held; reg_write=1 only in MEMWB; total 8 cycles.
4. beq with zero=1 -> pc_write=1 in BRANCH. bne with zero=1 and SUPPORT_BNE=1 -> pc_write=0. bne with SUPPORT_BNE=0 -> TRAP.
5. op=1111111 -> TRAP after DECODE, trap=1, strobes 0 for 10 cycles. Then rst low -> FETCH, trap=0, instret=0.
6. TIMEOUT=4, mem_ready=0 in FETCH -> TRAP after 4 wait cycles. Repeat with mem_ready=1 on the 4th cycle -> DECODE.
